// File: rtl/rmt_repair_ctrl_pkg.sv
// Shared types and sizing helpers for the RMT repair sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Contents: repair_state_t FSM encoding, default repair port count, pass-count helper.
package rmt_repair_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } repair_state_t;

    // Repair ports on the RMT; one mapping per port per repair cycle.
    localparam int N_REPAIR_PACKETS = 8;

    // Number of READ cycles needed to sweep every logical register.
    function automatic int n_passes(input int depth, input int n_packets);
        return (depth + n_packets - 1) / n_packets;
    endfunction

endpackage

// File: rtl/rmt_repair_ctrl_if.sv
// Bundles the AMT read port and the RMT repair write port of the repair sequencer.
// Latency: n/a (wiring). Backpressure: none, the RMT repair port always accepts.
// master = sequencer (drives AMT addresses and repair writes), slave = AMT/RMT side.
interface rmt_repair_ctrl_if #(
    parameter int N_PACKETS = 8,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 7
);
    logic [INDEX-1:0] amtRdAddr_o  [0:N_PACKETS-1];
    logic [WIDTH-1:0] amtRdData_i  [0:N_PACKETS-1];
    logic             repairFlag_o;
    logic [INDEX-1:0] repairAddr_o [0:N_PACKETS-1];
    logic [WIDTH-1:0] repairData_o [0:N_PACKETS-1];

    modport master (
        output amtRdAddr_o,
        input  amtRdData_i,
        output repairFlag_o,
        output repairAddr_o,
        output repairData_o
    );

    modport slave (
        input  amtRdAddr_o,
        output amtRdData_i,
        input  repairFlag_o,
        input  repairAddr_o,
        input  repairData_o
    );
endinterface

// File: rtl/rmt_repair_ctrl.sv
// Restores the speculative RMT from the AMT after recovery, N_PACKETS mappings per cycle.
// Latency: AMT read to RMT write 1 cycle; full repair ends N_PASSES+1 cycles after recoverFlag_i.
// Backpressure: none; busy_o stalls rename while running, recoverFlag_i restarts the sweep.
// Ports: clk, reset (sync, active-high), recoverFlag_i, bus (AMT read + RMT repair), busy_o, repairDone_o.
module rmt_repair_ctrl
    import rmt_repair_ctrl_pkg::*;
#(
    parameter int DEPTH     = 34,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 7,
    parameter int N_PACKETS = N_REPAIR_PACKETS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               recoverFlag_i,
    rmt_repair_ctrl_if.master  bus,
    output logic               busy_o,
    output logic               repairDone_o
);

    localparam int N_PASSES = n_passes(DEPTH, N_PACKETS);
    localparam int PTR_W    = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_PASSES - 1);
    localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

    repair_state_t    r_state;
    repair_state_t    w_next_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_done;

    logic [INDEX-1:0] w_lane_addr [0:N_PACKETS-1];
    logic             r_flag;
    logic [INDEX-1:0] r_addr      [0:N_PACKETS-1];
    logic [WIDTH-1:0] r_data      [0:N_PACKETS-1];

    // Lane address for the current pass; lanes past the table end clamp to
    // the last entry, producing identical duplicate writes the RMT ignores.
    for (genvar gi = 0; gi < N_PACKETS; gi++) begin : g_lane
        logic [31:0] w_raw;
        assign w_raw = 32'(r_ptr) * 32'(N_PACKETS) + 32'(gi);
        assign w_lane_addr[gi]     = (w_raw >= 32'(DEPTH)) ? LAST_IDX : w_raw[INDEX-1:0];
        assign bus.amtRdAddr_o[gi] = (r_state == READ) ? w_lane_addr[gi] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (recoverFlag_i) begin
                    w_next_state = READ;
                    w_next_ptr   = '0;
                end
            end
            READ: begin
                // A new recovery restarts the sweep; the packet being read now
                // is still valid because the AMT is frozen while busy.
                if (recoverFlag_i) begin
                    w_next_state = READ;
                    w_next_ptr   = '0;
                end else if (r_ptr == LAST_PTR) begin
                    w_next_state = DRAIN;
                    w_next_ptr   = '0;
                end else begin
                    w_next_ptr   = r_ptr + PTR_W'(1);
                end
            end
            DRAIN: begin
                // Final packet is on the repair port this cycle. A coincident
                // recovery supersedes it, so no completion is signalled.
                w_done     = !recoverFlag_i;
                w_next_ptr = '0;
                w_next_state = recoverFlag_i ? READ : IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_ptr   = '0;
            end
        endcase
    end

    // Repair outputs are registered copies of the AMT read; address/data hold
    // their last value while the write enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
            for (int i = 0; i < N_PACKETS; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (r_state == READ) begin
            r_flag <= 1'b1;
            for (int i = 0; i < N_PACKETS; i++) begin
                r_addr[i] <= w_lane_addr[i];
                r_data[i] <= bus.amtRdData_i[i];
            end
        end else begin
            r_flag <= 1'b0;
        end
    end

    assign bus.repairFlag_o = r_flag;
    assign bus.repairAddr_o = r_addr;
    assign bus.repairData_o = r_data;
    assign busy_o           = (r_state != IDLE);
    assign repairDone_o     = w_done;

endmodule

// File: tb/tb_rmt_repair_ctrl.sv
// Bench for rmt_repair_ctrl: two instances (DEPTH=34 and DEPTH=32, N_PACKETS=8) share stimulus.
// The reference derives expected outputs from the cycle of the latest valid recovery request.
// Ends with a single summary line.
module tb_rmt_repair_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic recover;
    logic busy34, done34, busy32, done32;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    logic [6:0] amt_mem [0:63];

    // Markers for hand-computed expectations; far away until set.
    int c_basic = 32'h3fff_0000;
    int c_rr    = 32'h3fff_0000;
    int c_rd    = 32'h3fff_0000;
    int c_rm    = 32'h3fff_0000;

    // Reference state: cycle of latest reset and latest accepted recovery.
    int last_rst = -1;
    int last_rec = -1000;
    logic       exp_flag [0:1];
    logic [5:0] exp_addr [0:1][0:7];
    logic [6:0] exp_data [0:1][0:7];

    rmt_repair_ctrl_if #(.N_PACKETS(8), .INDEX(6), .WIDTH(7)) if34 ();
    rmt_repair_ctrl_if #(.N_PACKETS(8), .INDEX(6), .WIDTH(7)) if32 ();

    for (genvar g = 0; g < 8; g++) begin : g_amt
        assign if34.amtRdData_i[g] = amt_mem[if34.amtRdAddr_o[g]];
        assign if32.amtRdData_i[g] = amt_mem[if32.amtRdAddr_o[g]];
    end

    rmt_repair_ctrl #(.DEPTH(34), .INDEX(6), .WIDTH(7), .N_PACKETS(8)) u34 (
        .clk(clk), .reset(reset), .recoverFlag_i(recover), .bus(if34.master),
        .busy_o(busy34), .repairDone_o(done34)
    );

    rmt_repair_ctrl #(.DEPTH(32), .INDEX(6), .WIDTH(7), .N_PACKETS(8)) u32 (
        .clk(clk), .reset(reset), .recoverFlag_i(recover), .bus(if32.master),
        .busy_o(busy32), .repairDone_o(done32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lane(input int depth, input int p, input int i);
        int a;
        a = p * 8 + i;
        return (a > depth - 1) ? depth - 1 : a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Compare one instance against the reference, then advance the reference
    // with this cycle's inputs.
    task automatic model_cfg(input int cfg, input logic busy, input logic done, input logic flag,
                             input logic [5:0] ra [0:7], input logic [6:0] rd [0:7],
                             input logic [5:0] aa [0:7]);
        int  np, depth, k, bad_ra, bad_rd, bad_aa, e;
        bit  in_read, in_drain;
        string tag;
        np    = (cfg == 0) ? 5 : 4;
        depth = (cfg == 0) ? 34 : 32;
        tag   = (cfg == 0) ? "d34" : "d32";
        k     = (last_rec > last_rst) ? (cyc - last_rec) : 1000;
        in_read  = (k >= 1) && (k <= np);
        in_drain = (k == np + 1);

        chk({tag, "_busy"}, int'(busy), int'(in_read || in_drain));
        chk({tag, "_done"}, int'(done), int'(in_drain && !recover));
        chk({tag, "_flag"}, int'(flag), int'(exp_flag[cfg]));
        bad_ra = -1; bad_rd = -1; bad_aa = -1;
        for (int i = 0; i < 8; i++) begin
            e = in_read ? lane(depth, k - 1, i) : 0;
            if (aa[i] !== 6'(e) && bad_aa < 0) bad_aa = i;
            if (ra[i] !== exp_addr[cfg][i] && bad_ra < 0) bad_ra = i;
            if (rd[i] !== exp_data[cfg][i] && bad_rd < 0) bad_rd = i;
        end
        if (bad_aa < 0) chk({tag, "_amtaddr"}, 0, 0);
        else chk({tag, "_amtaddr_lane"}, int'(aa[bad_aa]), in_read ? lane(depth, k - 1, bad_aa) : 0);
        if (bad_ra < 0) chk({tag, "_repaddr"}, 0, 0);
        else chk({tag, "_repaddr_lane"}, int'(ra[bad_ra]), int'(exp_addr[cfg][bad_ra]));
        if (bad_rd < 0) chk({tag, "_repdata"}, 0, 0);
        else chk({tag, "_repdata_lane"}, int'(rd[bad_rd]), int'(exp_data[cfg][bad_rd]));

        if (reset) begin
            exp_flag[cfg] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                exp_addr[cfg][i] = '0;
                exp_data[cfg][i] = '0;
            end
        end else if (in_read) begin
            exp_flag[cfg] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                exp_addr[cfg][i] = 6'(lane(depth, k - 1, i));
                exp_data[cfg][i] = amt_mem[lane(depth, k - 1, i)];
            end
        end else begin
            exp_flag[cfg] = 1'b0;
        end
    endtask

    // Single compare process, sampling on the falling edge.
    initial begin
        for (int c = 0; c < 2; c++) begin
            exp_flag[c] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                exp_addr[c][i] = '0;
                exp_data[c][i] = '0;
            end
        end
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                model_cfg(0, busy34, done34, if34.repairFlag_o, if34.repairAddr_o,
                          if34.repairData_o, if34.amtRdAddr_o);
                model_cfg(1, busy32, done32, if32.repairFlag_o, if32.repairAddr_o,
                          if32.repairData_o, if32.amtRdAddr_o);

                // Hand-computed expectations that pin the reference itself.
                if (cyc == 2) begin
                    chk("rst_flag", int'(if34.repairFlag_o), 0);
                    chk("rst_data0", int'(if34.repairData_o[0]), 0);
                end
                if (cyc == 3) chk("rst_recover_ignored", int'(busy34), 0);
                if (cyc == c_basic + 2) chk("basic_flag_first", int'(if34.repairFlag_o), 1);
                if (cyc == c_basic + 5) chk("basic_done_early", int'(done34), 0);
                if (cyc == c_basic + 6) begin
                    chk("basic_p4_addr0", int'(if34.repairAddr_o[0]), 32);
                    chk("basic_p4_addr1", int'(if34.repairAddr_o[1]), 33);
                    chk("basic_p4_addr7", int'(if34.repairAddr_o[7]), 33);
                    chk("basic_p4_data0", int'(if34.repairData_o[0]), 72);
                    chk("basic_p4_data7", int'(if34.repairData_o[7]), 73);
                    chk("basic_done", int'(done34), 1);
                end
                if (cyc == c_basic + 7) chk("basic_idle", int'(busy34), 0);
                if (cyc == c_basic + 4) chk("exact_done_early", int'(done32), 0);
                if (cyc == c_basic + 5) begin
                    chk("exact_done", int'(done32), 1);
                    chk("exact_p3_addr7", int'(if32.repairAddr_o[7]), 31);
                end
                if (cyc == c_rr + 4) chk("rr_restart_amt1", int'(if34.amtRdAddr_o[1]), 1);
                if (cyc == c_rr + 8) chk("rr_done_early", int'(done34), 0);
                if (cyc == c_rr + 9) chk("rr_done", int'(done34), 1);
                if (cyc == c_rd + 6) chk("rd_done_suppressed", int'(done34), 0);
                if (cyc == c_rd + 7) chk("rd_gap_flag", int'(if34.repairFlag_o), 0);
                if (cyc == c_rd + 8) chk("rd_flag_restart", int'(if34.repairFlag_o), 1);
                if (cyc == c_rd + 12) chk("rd_done", int'(done34), 1);
                if (cyc == c_rm + 4) begin
                    chk("rm_flag", int'(if34.repairFlag_o), 0);
                    chk("rm_busy", int'(busy34), 0);
                end
            end
            if (reset) last_rst = cyc;
            else if (recover) last_rec = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus.
    initial begin
        for (int j = 0; j < 64; j++) amt_mem[j] = 7'(j + 40);
        reset   = 1'b1;
        recover = 1'b1;
        step();
        step();
        reset   = 1'b0;
        recover = 1'b0;
        repeat (3) step();

        // Basic repair.
        recover = 1'b1; c_basic = cyc; step(); recover = 1'b0;
        repeat (12) step();

        // Restart while reading.
        recover = 1'b1; c_rr = cyc; step(); recover = 1'b0;
        repeat (2) step();
        recover = 1'b1; step(); recover = 1'b0;
        repeat (12) step();

        // Restart in the drain cycle.
        recover = 1'b1; c_rd = cyc; step(); recover = 1'b0;
        repeat (5) step();
        recover = 1'b1; step(); recover = 1'b0;
        repeat (14) step();

        // Reset mid-repair.
        recover = 1'b1; c_rm = cyc; step(); recover = 1'b0;
        repeat (2) step();
        reset = 1'b1; step(); reset = 1'b0;
        repeat (10) step();

        // Randomized traffic with AMT content changes.
        for (int n = 0; n < 1500; n++) begin
            recover = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) amt_mem[$urandom_range(0, 63)] = 7'($urandom);
            step();
        end
        reset   = 1'b0;
        recover = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
